// File: rtl/rgb444_to_rgb332_packer.sv
// ----------------------------------------------------------------------------
// rgb444_to_rgb332_packer
//
// This block reduces a stream of RGB444 pixels to RGB332 bytes and packs them
// into frame-buffer words. It is the capture-side inverse of the display
// expansion {0,r[2:0]}, {0,g[2:0]}, {00,b[1:0]}.
//
// The byte format is {r[2:0], g[2:0], b[1:0]}. Pixel k of a word is placed in
// m_data[8k+7:8k].
//
// Configuration macro RGB332_SCALE_EN:
//   - Undefined (default): saturating inverse mapping. sat_flag reports clipping.
//   - Defined: proportional MSB truncation. sat_flag is tied to 0.
//
// Ports:
//   clk, rst_n        pixel clock, asynchronous active-low reset
//   s_valid/s_ready   input pixel handshake
//   s_r, s_g, s_b     RGB444 components
//   s_user            start-of-frame (first pixel of a frame)
//   s_last            end-of-line (last pixel of a line)
//   m_valid/m_ready   output word handshake
//   m_data            packed RGB332 bytes
//   m_keep            byte enables
//   m_user            word contains the start-of-frame pixel
//   m_last            word contains the end-of-line pixel
//   sat_flag          sticky saturation seen since the last accepted s_user
// ----------------------------------------------------------------------------
module rgb444_to_rgb332_packer #(
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter int unsigned DATA_W         = 8 * BYTES_PER_WORD
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [3:0]                s_r,
    input  logic [3:0]                s_g,
    input  logic [3:0]                s_b,
    input  logic                      s_user,
    input  logic                      s_last,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [DATA_W-1:0]         m_data,
    output logic [BYTES_PER_WORD-1:0] m_keep,
    output logic                      m_user,
    output logic                      m_last,
    output logic                      sat_flag
);

    localparam int unsigned IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    // Accumulator state
    logic [DATA_W-1:0]         r_acc;
    logic [IDX_W-1:0]          r_idx;
    logic                      r_acc_user;
    logic                      r_sat;

    // Output register
    logic                      r_m_valid;
    logic [DATA_W-1:0]         r_m_data;
    logic [BYTES_PER_WORD-1:0] r_m_keep;
    logic                      r_m_user;
    logic                      r_m_last;

    logic [2:0]                w_r3;
    logic [2:0]                w_g3;
    logic [1:0]                w_b2;
    logic                      w_px_sat;
    logic [7:0]                w_byte;
    logic [DATA_W-1:0]         w_word;
    logic [BYTES_PER_WORD-1:0] w_keep;
    logic [BYTES_PER_WORD-1:0] w_flush_keep;
    logic                      w_out_free;
    logic                      w_mid_word;
    logic                      w_xfer;
    logic                      w_complete;
    logic                      w_flush;

    // ------------------------------------------------------------------------
    // Component reduction
    // ------------------------------------------------------------------------
`ifdef RGB332_SCALE_EN
    logic w_unused_lsbs;

    assign w_r3          = s_r[3:1];
    assign w_g3          = s_g[3:1];
    assign w_b2          = s_b[3:2];
    assign w_px_sat      = 1'b0;
    assign w_unused_lsbs = ^{s_r[0], s_g[0], s_b[1:0]};
`else
    // Values outside the range the display expansion can produce clip to full scale.
    assign w_r3     = s_r[3] ? 3'b111 : s_r[2:0];
    assign w_g3     = s_g[3] ? 3'b111 : s_g[2:0];
    assign w_b2     = (s_b[3] | s_b[2]) ? 2'b11 : s_b[1:0];
    assign w_px_sat = s_r[3] | s_g[3] | s_b[3] | s_b[2];
`endif

    assign w_byte = {w_r3, w_g3, w_b2};

    // ------------------------------------------------------------------------
    // Handshake and word-completion decode
    // ------------------------------------------------------------------------
    assign w_out_free = ~r_m_valid | m_ready;
    assign w_mid_word = (r_idx != '0);

    // A start-of-frame pixel arriving mid-word is held off for one cycle while
    // the partial word is flushed. The pixel then starts a fresh word.
    assign s_ready    = w_out_free & ~(s_user & w_mid_word);
    assign w_xfer     = s_valid & s_ready;
    assign w_complete = w_xfer & ((r_idx == LAST_IDX) | s_last);
    assign w_flush    = s_valid & s_user & w_mid_word & w_out_free;

    // Merge the new byte at idx and build the byte enables for both a normal
    // completion (bytes 0..idx) and a forced flush (bytes 0..idx-1).
    always_comb begin
        w_word       = r_acc;
        w_keep       = '0;
        w_flush_keep = '0;
        for (int k = 0; k < BYTES_PER_WORD; k++) begin
            if (IDX_W'(k) == r_idx) begin
                w_word[8*k +: 8] = w_byte;
            end
            if (IDX_W'(k) <= r_idx) begin
                w_keep[k] = 1'b1;
            end
            if (IDX_W'(k) < r_idx) begin
                w_flush_keep[k] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Accumulator
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_idx      <= '0;
            r_acc_user <= 1'b0;
        end else if (w_complete || w_flush) begin
            r_acc      <= '0;
            r_idx      <= '0;
            r_acc_user <= 1'b0;
        end else if (w_xfer) begin
            r_acc      <= w_word;
            r_idx      <= r_idx + 1'b1;
            r_acc_user <= r_acc_user | s_user;
        end
    end

    // ------------------------------------------------------------------------
    // Sticky saturation flag, restarted by each accepted start-of-frame pixel
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat <= 1'b0;
        end else if (w_xfer) begin
            r_sat <= s_user ? w_px_sat : (r_sat | w_px_sat);
        end
    end

    // ------------------------------------------------------------------------
    // Output register. Completion and flush are exclusive because a flush
    // cycle never accepts a pixel.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_keep  <= '0;
            r_m_user  <= 1'b0;
            r_m_last  <= 1'b0;
        end else if (w_complete) begin
            r_m_valid <= 1'b1;
            r_m_data  <= w_word;
            r_m_keep  <= w_keep;
            r_m_user  <= r_acc_user | s_user;
            r_m_last  <= s_last;
        end else if (w_flush) begin
            r_m_valid <= 1'b1;
            r_m_data  <= r_acc;
            r_m_keep  <= w_flush_keep;
            r_m_user  <= r_acc_user;
            r_m_last  <= 1'b0;
        end else if (m_ready) begin
            r_m_valid <= 1'b0;
        end
    end

    assign m_valid  = r_m_valid;
    assign m_data   = r_m_data;
    assign m_keep   = r_m_keep;
    assign m_user   = r_m_user;
    assign m_last   = r_m_last;
    assign sat_flag = r_sat;

endmodule

// File: tb/tb_rgb444_to_rgb332_packer.sv
// ----------------------------------------------------------------------------
// Testbench for rgb444_to_rgb332_packer (BYTES_PER_WORD = 4).
// Honours RGB332_SCALE_EN the same way as the design.
// ----------------------------------------------------------------------------
module tb_rgb444_to_rgb332_packer;

    localparam int BPW = 4;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        user;
        logic        last;
    } word_t;

    logic        clk;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [3:0]  s_r;
    logic [3:0]  s_g;
    logic [3:0]  s_b;
    logic        s_user;
    logic        s_last;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_user;
    logic        m_last;
    logic        sat_flag;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_words  = 0;
    bit          rnd_ready = 0;

    // Reference model state
    word_t       exp_q[$];
    logic [31:0] pend_data;
    int          pend_n;
    logic        pend_user;
    logic        mdl_sat;

    rgb444_to_rgb332_packer #(
        .BYTES_PER_WORD(BPW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_r     (s_r),
        .s_g     (s_g),
        .s_b     (s_b),
        .s_user  (s_user),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_keep  (m_keep),
        .m_user  (m_user),
        .m_last  (m_last),
        .sat_flag(sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_byte(input int r, input int g, input int b);
        int r3, g3, b2;
`ifdef RGB332_SCALE_EN
        r3 = r / 2;
        g3 = g / 2;
        b2 = b / 4;
`else
        r3 = (r >= 8) ? 7 : r;
        g3 = (g >= 8) ? 7 : g;
        b2 = (b >= 4) ? 3 : b;
`endif
        return 8'(r3 * 32 + g3 * 4 + b2);
    endfunction

    function automatic bit ref_sat(input int r, input int g, input int b);
`ifdef RGB332_SCALE_EN
        return 1'b0;
`else
        return (r >= 8) || (g >= 8) || (b >= 4);
`endif
    endfunction

    task automatic emit(input logic last);
        word_t w;
        w.data = pend_data;
        w.keep = 4'((1 << pend_n) - 1);
        w.user = pend_user;
        w.last = last;
        exp_q.push_back(w);
        pend_data = '0;
        pend_n    = 0;
        pend_user = 1'b0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        pend_data = '0;
        pend_n    = 0;
        pend_user = 1'b0;
        mdl_sat   = 1'b0;
    endtask

    // Model and scoreboard, sampled on the falling edge. Inputs are taken
    // before outputs so a word predicted this cycle can be matched this cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            word_t w;
            chk("sat_flag", sat_flag, mdl_sat);
            if (s_valid && s_ready) begin
                if (s_user) begin
                    if (pend_n > 0) emit(1'b0);
                    mdl_sat = ref_sat(s_r, s_g, s_b);
                end else begin
                    mdl_sat = mdl_sat | ref_sat(s_r, s_g, s_b);
                end
                pend_data = pend_data | (32'(ref_byte(s_r, s_g, s_b)) << (8 * pend_n));
                pend_n++;
                pend_user = pend_user | s_user;
                if (pend_n == BPW || s_last) emit(s_last);
            end
            if (m_valid && m_ready) begin
                n_words++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 64'(m_data), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    w = exp_q.pop_front();
                    chk("sb_data", m_data, w.data);
                    chk("sb_keep", m_keep, w.keep);
                    chk("sb_user", m_user, w.user);
                    chk("sb_last", m_last, w.last);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) m_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Present one pixel and hold it until accepted; waits = stalled cycles.
    task automatic send(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                        input logic user, input logic last, output int waits);
        bit acc;
        s_r     = r;
        s_g     = g;
        s_b     = b;
        s_user  = user;
        s_last  = last;
        s_valid = 1'b1;
        waits   = 0;
        forever begin
            @(negedge clk);
            acc = s_ready;
            tick();
            if (acc) break;
            waits++;
            if (waits > 200) begin
                n_checks++;
                n_errors++;
                $error("FAIL send_timeout: observed=stalled expected=accepted");
                break;
            end
        end
        s_valid = 1'b0;
        s_user  = 1'b0;
        s_last  = 1'b0;
    endtask

    initial begin
        int w;
        logic [31:0] exp_word;

        s_valid = 0;
        s_r     = 0;
        s_g     = 0;
        s_b     = 0;
        s_user  = 0;
        s_last  = 0;
        m_ready = 1;
        rst_n   = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_data", m_data, 32'h0);
        chk("rst_m_keep", m_keep, 4'h0);
        chk("rst_m_user", m_user, 1'b0);
        chk("rst_m_last", m_last, 1'b0);
        chk("rst_sat", sat_flag, 1'b0);
        chk("rst_s_ready", s_ready, 1'b1);
        rst_n = 1;
        idle(2);

        // First word and its 1-cycle latency
        send(4'd1, 4'd2, 4'd3, 1'b0, 1'b0, w);
        send(4'd7, 4'd7, 4'd3, 1'b0, 1'b0, w);
        send(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, w);
        chk("pre_word_valid", m_valid, 1'b0);
        send(4'd5, 4'd1, 4'd2, 1'b0, 1'b0, w);
        @(negedge clk);
        chk("word1_valid", m_valid, 1'b1);
`ifdef RGB332_SCALE_EN
        chk("word1_data", m_data, 32'h4000_6C04);
`else
        chk("word1_data", m_data, 32'hA600_FF2B);
`endif
        chk("word1_keep", m_keep, 4'hF);
        idle(2);

        // Saturating pixel, then an SOF pixel restarts the flag
        send(4'hF, 4'h8, 4'hC, 1'b0, 1'b1, w);
        @(negedge clk);
`ifdef RGB332_SCALE_EN
        chk("sat_byte", m_data[7:0], 8'hF3);
        chk("sat_set", sat_flag, 1'b0);
`else
        chk("sat_byte", m_data[7:0], 8'hFF);
        chk("sat_set", sat_flag, 1'b1);
`endif
        chk("sat_keep", m_keep, 4'h1);
        send(4'd1, 4'd1, 4'd1, 1'b1, 1'b1, w);
        @(negedge clk);
        chk("sat_clear", sat_flag, 1'b0);
        chk("sof_user", m_user, 1'b1);
        idle(2);

        // Six-pixel line: full word then a 2-byte word with zero padding
        for (int i = 0; i < 6; i++) begin
            send(4'(i + 2), 4'(i), 4'(i + 1), 1'b0, (i == 5), w);
        end
        @(negedge clk);
        chk("line_keep", m_keep, 4'h3);
        chk("line_last", m_last, 1'b1);
        chk("line_pad", m_data[31:16], 16'h0);
        idle(2);

        // Output stall for 10 cycles
        m_ready = 0;
        for (int i = 0; i < 4; i++) send(4'(i), 4'(3 - i), 4'(i), 1'b0, 1'b0, w);
        exp_word = {ref_byte(3, 0, 3), ref_byte(2, 1, 2), ref_byte(1, 2, 1), ref_byte(0, 3, 0)};
        s_r     = 4'd6;
        s_g     = 4'd5;
        s_b     = 4'd2;
        s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) chk("stall_s_ready0", s_ready, 1'b0);
        end
        chk("stall_s_ready9", s_ready, 1'b0);
        chk("stall_valid", m_valid, 1'b1);
        chk("stall_data", m_data, exp_word);
        m_ready = 1;
        send(4'd6, 4'd5, 4'd2, 1'b0, 1'b0, w);
        for (int i = 0; i < 3; i++) send(4'(i + 9), 4'(i), 4'(i + 4), 1'b0, 1'b0, w);
        idle(3);

        // Reset mid-word
        send(4'd3, 4'd3, 4'd3, 1'b0, 1'b0, w);
        send(4'd4, 4'd4, 4'd0, 1'b0, 1'b0, w);
        rst_n = 0;
        #1;
        chk("mid_rst_valid", m_valid, 1'b0);
        chk("mid_rst_data", m_data, 32'h0);
        chk("mid_rst_keep", m_keep, 4'h0);
        chk("mid_rst_sat", sat_flag, 1'b0);
        model_reset();
        idle(2);
        rst_n = 1;
        idle(1);
        for (int i = 0; i < 4; i++) send(4'(i + 1), 4'(i + 1), 4'(i), 1'b0, 1'b0, w);
        @(negedge clk);
        chk("post_rst_keep", m_keep, 4'hF);
        chk("post_rst_valid", m_valid, 1'b1);
        idle(2);

        // Mid-word SOF: 2 pending bytes flushed, SOF pixel held for one cycle
        send(4'd2, 4'd2, 4'd2, 1'b0, 1'b0, w);
        send(4'd3, 4'd1, 4'd0, 1'b0, 1'b0, w);
        send(4'd1, 4'd6, 4'd3, 1'b1, 1'b0, w);
        chk("sof_stall", w, 1);
        for (int i = 0; i < 3; i++) send(4'(i), 4'(i), 4'(i), 1'b0, 1'b0, w);
        idle(2);

        // Randomised traffic with random back-pressure
        rnd_ready = 1;
        for (int i = 0; i < 400; i++) begin
            send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 5) == 0), w);
            if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
        end
        rnd_ready = 0;
        m_ready   = 1;
        // Close any partial word so nothing is left pending
        send(4'd0, 4'd0, 4'd0, 1'b0, 1'b1, w);
        idle(5);
        chk("drain_empty", exp_q.size(), 0);
        chk("drain_pending", pend_n, 0);
        chk("words_seen", (n_words > 50), 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
